// File: rtl/tpu_sequencer.sv
// tpu_sequencer
// Instruction-driven controller for the TPU datapath. The host pushes 64-bit
// instructions into an internal FIFO; a start pulse makes the sequencer pop and
// execute them in order until HALT, driving the unified-buffer read controls,
// the systolic weight switch and the VPU pathway select.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   instr_in/instr_valid_in  host instruction push
//   instr_ready_out          FIFO has room
//   start_in                 begin execution (honoured only in IDLE)
//   vpu_valid_in_1/2         VPU output valids, watched by WAIT_VPU
//   ub_rd_start_out          one-cycle UB read launch
//   ub_rd_*_out              latched READ fields
//   sys_switch_out           one-cycle systolic switch pulse
//   vpu_data_pathway_out     latched SETPATH value
//   busy_out                 not IDLE
//   done_out                 one-cycle pulse on HALT
//   error_out                sticky illegal-opcode flag
//   fifo_count_out           FIFO occupancy
module tpu_sequencer #(
    parameter int FIFO_DEPTH = 16,
    parameter int INSTR_W    = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [INSTR_W-1:0]            instr_in,
    input  logic                          instr_valid_in,
    output logic                          instr_ready_out,
    input  logic                          start_in,
    input  logic                          vpu_valid_in_1,
    input  logic                          vpu_valid_in_2,
    output logic                          ub_rd_start_out,
    output logic                          ub_rd_transpose_out,
    output logic [8:0]                    ub_ptr_select_out,
    output logic [15:0]                   ub_rd_addr_out,
    output logic [15:0]                   ub_rd_row_size_out,
    output logic [15:0]                   ub_rd_col_size_out,
    output logic                          sys_switch_out,
    output logic [3:0]                    vpu_data_pathway_out,
    output logic                          busy_out,
    output logic                          done_out,
    output logic                          error_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_HALTED = 3'd4;

    localparam logic [3:0] OP_NOP      = 4'd0;
    localparam logic [3:0] OP_READ     = 4'd1;
    localparam logic [3:0] OP_SWITCH   = 4'd2;
    localparam logic [3:0] OP_SETPATH  = 4'd3;
    localparam logic [3:0] OP_WAIT     = 4'd4;
    localparam logic [3:0] OP_WAIT_VPU = 4'd5;
    localparam logic [3:0] OP_HALT     = 4'd15;

    logic [INSTR_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count_q;
    logic               push;
    logic               pop;
    logic [INSTR_W-1:0] head;

    logic [2:0]  state;
    logic [3:0]  ir_op;
    logic [13:0] ir_count;
    logic [13:0] wait_cnt;

    assign instr_ready_out = (count_q != FULL_COUNT);
    assign push            = instr_valid_in && instr_ready_out;
    assign pop             = (state == S_FETCH) && (count_q != '0);
    assign head            = mem[rd_ptr];
    assign fifo_count_out  = count_q;
    assign busy_out        = (state != S_IDLE);
    assign done_out        = (state == S_HALTED);

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= instr_in;
        end
    end

    // Pointer wrap is free because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Control FSM. Pulses and latched fields are decoded from the FIFO head at
    // the pop edge so they are visible during the EXEC cycle itself; EXEC then
    // only decides where to go next.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= S_IDLE;
            ir_op                <= OP_NOP;
            ir_count             <= '0;
            wait_cnt             <= '0;
            ub_rd_start_out      <= 1'b0;
            ub_rd_transpose_out  <= 1'b0;
            ub_ptr_select_out    <= '0;
            ub_rd_addr_out       <= '0;
            ub_rd_row_size_out   <= '0;
            ub_rd_col_size_out   <= '0;
            sys_switch_out       <= 1'b0;
            vpu_data_pathway_out <= '0;
            error_out            <= 1'b0;
        end else begin
            ub_rd_start_out <= 1'b0;
            sys_switch_out  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_in) begin
                        error_out <= 1'b0;
                        state     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (pop) begin
                        ir_op    <= head[63:60];
                        ir_count <= head[13:0];
                        state    <= S_EXEC;
                        case (head[63:60])
                            OP_READ: begin
                                ub_rd_start_out     <= 1'b1;
                                ub_rd_transpose_out <= head[59];
                                ub_ptr_select_out   <= head[58:50];
                                ub_rd_addr_out      <= head[45:30];
                                ub_rd_row_size_out  <= {8'd0, head[29:22]};
                                ub_rd_col_size_out  <= {8'd0, head[21:14]};
                            end
                            OP_SWITCH:  sys_switch_out       <= 1'b1;
                            OP_SETPATH: vpu_data_pathway_out <= head[49:46];
                            default: ;
                        endcase
                    end
                end
                S_EXEC: begin
                    case (ir_op)
                        OP_NOP, OP_READ, OP_SWITCH, OP_SETPATH: state <= S_FETCH;
                        OP_WAIT, OP_WAIT_VPU: begin
                            if (ir_count == '0) begin
                                state <= S_FETCH;
                            end else begin
                                wait_cnt <= ir_count;
                                state    <= S_WAIT;
                            end
                        end
                        OP_HALT: state <= S_HALTED;
                        default: begin
                            error_out <= 1'b1;
                            state     <= S_HALTED;
                        end
                    endcase
                end
                S_WAIT: begin
                    // Any VPU activity restarts the quiet-period count.
                    if ((ir_op == OP_WAIT_VPU) && (vpu_valid_in_1 || vpu_valid_in_2)) begin
                        wait_cnt <= ir_count;
                    end else begin
                        wait_cnt <= wait_cnt - 14'd1;
                        if (wait_cnt == 14'd1) begin
                            state <= S_FETCH;
                        end
                    end
                end
                S_HALTED: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_sequencer.sv
// tb_tpu_sequencer
// Directed bench for tpu_sequencer: a cycle-by-cycle vector table for a basic
// READ/HALT program, then hand-written sequences for switch spacing around
// WAIT, WAIT_VPU quiet periods, FIFO full/stall behaviour, illegal opcodes and
// reset during a wait.
module tb_tpu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] instr_in;
    logic        instr_valid_in;
    logic        instr_ready_out;
    logic        start_in;
    logic        vpu_valid_in_1;
    logic        vpu_valid_in_2;
    logic        ub_rd_start_out;
    logic        ub_rd_transpose_out;
    logic [8:0]  ub_ptr_select_out;
    logic [15:0] ub_rd_addr_out;
    logic [15:0] ub_rd_row_size_out;
    logic [15:0] ub_rd_col_size_out;
    logic        sys_switch_out;
    logic [3:0]  vpu_data_pathway_out;
    logic        busy_out;
    logic        done_out;
    logic        error_out;
    logic [4:0]  fifo_count_out;

    always #5 clk = ~clk;

    tpu_sequencer #(.FIFO_DEPTH(16), .INSTR_W(64)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .instr_in             (instr_in),
        .instr_valid_in       (instr_valid_in),
        .instr_ready_out      (instr_ready_out),
        .start_in             (start_in),
        .vpu_valid_in_1       (vpu_valid_in_1),
        .vpu_valid_in_2       (vpu_valid_in_2),
        .ub_rd_start_out      (ub_rd_start_out),
        .ub_rd_transpose_out  (ub_rd_transpose_out),
        .ub_ptr_select_out    (ub_ptr_select_out),
        .ub_rd_addr_out       (ub_rd_addr_out),
        .ub_rd_row_size_out   (ub_rd_row_size_out),
        .ub_rd_col_size_out   (ub_rd_col_size_out),
        .sys_switch_out       (sys_switch_out),
        .vpu_data_pathway_out (vpu_data_pathway_out),
        .busy_out             (busy_out),
        .done_out             (done_out),
        .error_out            (error_out),
        .fifo_count_out       (fifo_count_out)
    );

    typedef struct {
        logic        valid;
        logic [63:0] instr;
        logic        start;
        logic        exp_ub;
        logic        exp_busy;
        logic        exp_done;
        logic [4:0]  exp_count;
        logic        exp_ready;
    } vec_t;

    vec_t vecs[8];

    int checks = 0;
    int errors = 0;

    int sw1, sw2, swCnt, ubCnt, doneCyc, errAtDone, errAt1;
    logic [3:0] pathLog [0:63];

    logic [63:0] iNop, iHalt, iRead, iSwitch, iSetpath;

    // Inputs change 1 time unit after the rising edge; outputs read then are
    // the values of the cycle just entered.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        instr_valid_in = v.valid;
        instr_in       = v.instr;
        start_in       = v.start;
    endtask

    function automatic logic [63:0] mk(input logic [3:0] op, input logic tr, input logic [8:0] ptr,
                                       input logic [3:0] path, input logic [15:0] addr,
                                       input logic [7:0] row, input logic [7:0] col,
                                       input logic [13:0] cnt);
        return {op, tr, ptr, path, addr, row, col, cnt};
    endfunction

    task automatic pushInstr(input logic [63:0] ins);
        instr_valid_in = 1'b1;
        instr_in       = ins;
        tick();
        instr_valid_in = 1'b0;
    endtask

    // Pulses start and follows the program; cycle 1 is the FETCH after start.
    task automatic runTrace(input int budget, input int vLo, input int vHi);
        sw1 = 0; sw2 = 0; swCnt = 0; ubCnt = 0; doneCyc = 0; errAtDone = 0; errAt1 = 0;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            if (c < 64) pathLog[c] = vpu_data_pathway_out;
            if (c == 1) errAt1 = int'(error_out);
            if (sys_switch_out) begin
                swCnt++;
                if (swCnt == 1) sw1 = c;
                else if (swCnt == 2) sw2 = c;
            end
            if (ub_rd_start_out) ubCnt++;
            if (done_out) begin
                doneCyc   = c;
                errAtDone = int'(error_out);
                break;
            end
            vpu_valid_in_1 = (c >= vLo) && (c <= vHi);
            tick();
        end
        vpu_valid_in_1 = 1'b0;
        if (doneCyc == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: got no done within %0d cycles expected done", budget);
        end else begin
            tick();
        end
    endtask

    initial begin
        int doneSeen;
        int doneK;

        iNop     = mk(4'd0, 1'b0, 9'd0, 4'd0, 16'h0, 8'd0, 8'd0, 14'd0);
        iHalt    = mk(4'd15, 1'b0, 9'd0, 4'd0, 16'h0, 8'd0, 8'd0, 14'd0);
        iRead    = mk(4'd1, 1'b1, 9'd3, 4'd0, 16'h0010, 8'd2, 8'd2, 14'd0);
        iSwitch  = mk(4'd2, 1'b0, 9'd0, 4'd0, 16'h0, 8'd0, 8'd0, 14'd0);
        iSetpath = mk(4'd3, 1'b0, 9'd0, 4'b1011, 16'h0, 8'd0, 8'd0, 14'd0);

        // Table for a READ + HALT program: each row is one cycle of inputs and
        // the outputs expected in the cycle that follows.
        vecs[0] = '{1'b1, iRead, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1};
        vecs[1] = '{1'b1, iHalt, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 1'b1};
        vecs[2] = '{1'b0, iNop,  1'b1, 1'b0, 1'b1, 1'b0, 5'd2, 1'b1};
        vecs[3] = '{1'b0, iNop,  1'b0, 1'b1, 1'b1, 1'b0, 5'd1, 1'b1};
        vecs[4] = '{1'b0, iNop,  1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 1'b1};
        vecs[5] = '{1'b0, iNop,  1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1};
        vecs[6] = '{1'b0, iNop,  1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b1};
        vecs[7] = '{1'b0, iNop,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1};

        rst = 1'b1;
        instr_in = '0;
        instr_valid_in = 1'b0;
        start_in = 1'b0;
        vpu_valid_in_1 = 1'b0;
        vpu_valid_in_2 = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state.
        checkOutput("rst_ready", 32'(instr_ready_out), 32'd1);
        checkOutput("rst_count", 32'(fifo_count_out), 32'd0);
        checkOutput("rst_busy", 32'(busy_out), 32'd0);
        checkOutput("rst_done", 32'(done_out), 32'd0);
        checkOutput("rst_error", 32'(error_out), 32'd0);
        checkOutput("rst_ub_start", 32'(ub_rd_start_out), 32'd0);
        checkOutput("rst_path", 32'(vpu_data_pathway_out), 32'd0);

        // READ + HALT from the table.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
            tick();
            checkOutput($sformatf("vec%0d_ub_start", i), 32'(ub_rd_start_out), 32'(vecs[i].exp_ub));
            checkOutput($sformatf("vec%0d_busy", i), 32'(busy_out), 32'(vecs[i].exp_busy));
            checkOutput($sformatf("vec%0d_done", i), 32'(done_out), 32'(vecs[i].exp_done));
            checkOutput($sformatf("vec%0d_count", i), 32'(fifo_count_out), 32'(vecs[i].exp_count));
            checkOutput($sformatf("vec%0d_ready", i), 32'(instr_ready_out), 32'(vecs[i].exp_ready));
        end
        instr_valid_in = 1'b0;
        start_in = 1'b0;
        checkOutput("read_addr", 32'(ub_rd_addr_out), 32'h10);
        checkOutput("read_row", 32'(ub_rd_row_size_out), 32'd2);
        checkOutput("read_col", 32'(ub_rd_col_size_out), 32'd2);
        checkOutput("read_ptr", 32'(ub_ptr_select_out), 32'd3);
        checkOutput("read_transpose", 32'(ub_rd_transpose_out), 32'd1);

        // SETPATH 0b1011, SWITCH, HALT.
        pushInstr(iSetpath);
        pushInstr(iSwitch);
        pushInstr(iHalt);
        runTrace(30, 0, -1);
        checkOutput("path_before_exec", 32'(pathLog[1]), 32'd0);
        checkOutput("path_at_exec", 32'(pathLog[2]), 32'hB);
        checkOutput("switch_cycle", 32'(sw1), 32'd4);
        checkOutput("switch_count", 32'(swCnt), 32'd1);
        checkOutput("setpath_done_cycle", 32'(doneCyc), 32'd7);
        checkOutput("path_after_halt", 32'(vpu_data_pathway_out), 32'hB);

        // SWITCH, WAIT 5, SWITCH, HALT: 2 + 1 + 5 + 1 cycles between pulses.
        pushInstr(iSwitch);
        pushInstr(mk(4'd4, 1'b0, 9'd0, 4'd0, 16'h0, 8'd0, 8'd0, 14'd5));
        pushInstr(iSwitch);
        pushInstr(iHalt);
        runTrace(40, 0, -1);
        checkOutput("wait5_switch_gap", 32'(sw2 - sw1), 32'd9);
        checkOutput("wait5_done_cycle", 32'(doneCyc), 32'd14);

        // Same with WAIT 0: the wait costs only its EXEC and the next FETCH.
        pushInstr(iSwitch);
        pushInstr(mk(4'd4, 1'b0, 9'd0, 4'd0, 16'h0, 8'd0, 8'd0, 14'd0));
        pushInstr(iSwitch);
        pushInstr(iHalt);
        runTrace(40, 0, -1);
        checkOutput("wait0_switch_gap", 32'(sw2 - sw1), 32'd4);
        checkOutput("wait0_done_cycle", 32'(doneCyc), 32'd9);

        // WAIT_VPU 3 with valid_1 high for cycles 3..6: quiet from 7, FETCH at 10.
        pushInstr(mk(4'd5, 1'b0, 9'd0, 4'd0, 16'h0, 8'd0, 8'd0, 14'd3));
        pushInstr(iHalt);
        runTrace(40, 3, 6);
        checkOutput("waitvpu_done_cycle", 32'(doneCyc), 32'd12);

        // Fill the FIFO; the 17th push (a HALT) must be dropped.
        for (int i = 0; i < 17; i++) begin
            instr_valid_in = 1'b1;
            instr_in = (i == 16) ? iHalt : iNop;
            tick();
            if (i == 14) checkOutput("ready_at_15", 32'(instr_ready_out), 32'd1);
            if (i == 15) checkOutput("ready_at_16", 32'(instr_ready_out), 32'd0);
        end
        instr_valid_in = 1'b0;
        checkOutput("full_count", 32'(fifo_count_out), 32'd16);
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        doneSeen = 0;
        for (int c = 0; c < 40; c++) begin
            if (done_out) doneSeen++;
            tick();
        end
        checkOutput("stall_done_none", 32'(doneSeen), 32'd0);
        checkOutput("stall_busy", 32'(busy_out), 32'd1);
        checkOutput("stall_count", 32'(fifo_count_out), 32'd0);
        pushInstr(iHalt);
        doneK = 0;
        for (int k = 1; k <= 10; k++) begin
            if (done_out) begin
                doneK = k;
                break;
            end
            tick();
        end
        checkOutput("late_halt_done", 32'(doneK), 32'd3);
        tick();

        // Illegal opcode 7 halts with error and leaves the rest queued.
        pushInstr(mk(4'd7, 1'b0, 9'd0, 4'd0, 16'h0, 8'd0, 8'd0, 14'd0));
        pushInstr(iNop);
        pushInstr(iNop);
        runTrace(20, 0, -1);
        checkOutput("illegal_done_cycle", 32'(doneCyc), 32'd3);
        checkOutput("illegal_error_at_done", 32'(errAtDone), 32'd1);
        checkOutput("illegal_error_sticky", 32'(error_out), 32'd1);
        checkOutput("illegal_left_in_fifo", 32'(fifo_count_out), 32'd2);
        pushInstr(iHalt);
        runTrace(20, 0, -1);
        checkOutput("restart_error_cleared", 32'(errAt1), 32'd0);
        checkOutput("restart_done_cycle", 32'(doneCyc), 32'd7);
        checkOutput("restart_error_at_done", 32'(errAtDone), 32'd0);

        // Reset while in a long WAIT with an instruction still queued.
        pushInstr(mk(4'd4, 1'b0, 9'd0, 4'd0, 16'h0, 8'd0, 8'd0, 14'd20));
        pushInstr(iNop);
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        tick();
        tick();
        tick();
        checkOutput("prewait_busy", 32'(busy_out), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midrst_count", 32'(fifo_count_out), 32'd0);
        checkOutput("midrst_ready", 32'(instr_ready_out), 32'd1);
        checkOutput("midrst_busy", 32'(busy_out), 32'd0);
        checkOutput("midrst_done", 32'(done_out), 32'd0);
        checkOutput("midrst_addr", 32'(ub_rd_addr_out), 32'd0);
        checkOutput("midrst_ptr", 32'(ub_ptr_select_out), 32'd0);
        checkOutput("midrst_transpose", 32'(ub_rd_transpose_out), 32'd0);
        checkOutput("midrst_row", 32'(ub_rd_row_size_out), 32'd0);
        checkOutput("midrst_path", 32'(vpu_data_pathway_out), 32'd0);
        doneSeen = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (done_out || busy_out) doneSeen++;
        end
        checkOutput("postrst_quiet", 32'(doneSeen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
